// File: rtl/adc_sampler_if.sv
// adc_sampler_if: serial pins between the sampler (master) and an ADC (slave).
// adc_cs is active-low chip select, adc_clk idles high, adc_so is ADC data out.
interface adc_sampler_if;
  logic adc_cs;
  logic adc_clk;
  logic adc_so;

  modport master (
    output adc_cs,
    output adc_clk,
    input  adc_so
  );

  modport slave (
    input  adc_cs,
    input  adc_clk,
    output adc_so
  );
endinterface

// File: rtl/adc_sampler.sv
// adc_sampler: continuous serial ADC reader. Each frame lowers adc_cs, waits one
// adc_clk half-period, clocks 16 bits in MSB first on adc_clk rising edges, then
// keeps adc_cs high for QUIET_CYC clocks. A frame whose top nibble is non-zero
// is rejected with a frame_err strobe instead of a sample_valid strobe.
// Optional build macro ADC_SAMPLER_AVG_EN: sample becomes the truncated mean of
// the last four accepted results instead of the raw result.
module adc_sampler #(
  parameter int CLK_DIV   = 2,
  parameter int QUIET_CYC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  adc_sampler_if.master adc,
  output logic [11:0]   sample,
  output logic          sample_valid,
  output logic          frame_err,
  output logic          busy
);

  // Counter widths follow the parameters; at value 1 a single bit still works
  // because the last count is then zero and the counter never leaves it.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QT_W  = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [QT_W-1:0]  QT_LAST  = QT_W'(QUIET_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       half_q, half_d;
  logic [QT_W-1:0]  qt_q, qt_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic [15:0]      shift_q, shift_d;
  logic             eval_q, eval_d;
  logic [11:0]      sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [11:0]      result_w;

`ifdef ADC_SAMPLER_AVG_EN
  logic [11:0] hist0_q, hist1_q, hist2_q;

  function automatic logic [11:0] avg4(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c, input logic [11:0] d);
    logic [13:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return sum[13:2];
  endfunction

  assign result_w = avg4(shift_q[11:0], hist0_q, hist1_q, hist2_q);

  // Age the three-deep history with each accepted raw result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (eval_q && (shift_q[15:12] == 4'h0)) begin
      hist2_q <= hist1_q;
      hist1_q <= hist0_q;
      hist0_q <= shift_q[11:0];
    end
  end
`else
  assign result_w = shift_q[11:0];
`endif

  // Frame sequencing, serial clock generation, bit capture and result decode
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    qt_d     = qt_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    shift_d  = shift_q;
    eval_d   = 1'b0;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          div_d   = '0;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          half_d = half_q + 5'd1;
          if (!sclk_q) begin
            // Rising adc_clk: data has been stable for the whole low half
            sclk_d  = 1'b1;
            shift_d = {shift_q[14:0], adc.adc_so};
          end else if (half_q == 5'd31) begin
            state_d = QUIET;
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
            qt_d    = '0;
            eval_d  = 1'b1;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      QUIET: begin
        if (qt_q == QT_LAST) begin
          // Passing straight through IDLE keeps back-to-back frames gapless
          if (en) begin
            state_d = SETUP;
            cs_d    = 1'b0;
            div_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          qt_d = qt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (eval_q) begin
      if (shift_q[15:12] == 4'h0) begin
        sample_d = result_w;
        valid_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State register; reset parks the block idle with the ADC deselected
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      half_q   <= '0;
      qt_q     <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      shift_q  <= '0;
      eval_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      qt_q     <= qt_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      shift_q  <= shift_d;
      eval_q   <= eval_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign adc.adc_cs   = cs_q;
  assign adc.adc_clk  = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: scoreboard bench for adc_sampler. A behavioural ADC picks a
// word at every chip-select fall and predicts the strobe it must cause; a
// monitor pops predictions whenever a strobe appears. A second instance runs
// at CLK_DIV=1 for the fastest serial clock.
`timescale 1ns/1ps
module tb_adc_sampler;
  localparam int  CD  = 2;
  localparam int  QC  = 4;
  localparam int  LAT = CD + 32 * CD + 1;
  localparam int  PER = CD + 32 * CD + QC;
  localparam longint TCLK = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic en_f = 1'b0;
  always #10 clk = ~clk;

  adc_sampler_if ifc();
  adc_sampler_if ifc_f();
  logic [11:0] sample, sample_f;
  logic sample_valid, frame_err, busy;
  logic valid_f, err_f, busy_f;

  adc_sampler #(.CLK_DIV(CD), .QUIET_CYC(QC)) u_dut (
    .clk(clk), .reset(reset), .en(en), .adc(ifc.master),
    .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err), .busy(busy)
  );

  adc_sampler #(.CLK_DIV(1), .QUIET_CYC(1)) u_fast (
    .clk(clk), .reset(reset), .en(en_f), .adc(ifc_f.master),
    .sample(sample_f), .sample_valid(valid_f), .frame_err(err_f), .busy(busy_f)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          err;
    logic [11:0] smp;
    longint      tf;
  } exp_t;

  exp_t        exp_q[$];
  longint      fall_t[$];
  logic [15:0] word_q[$];
  logic [15:0] fixed_word = 16'h0ABC;
  bit          rand_mode = 1'b0;

  // ---------------- behavioural ADC + reference model ----------------
  logic [15:0] cur_w = 16'h0000;
  int          rises = 0;
  logic        prev_cs = 1'b1;
  logic [11:0] model_sample = 12'h000;
  exp_t        e_new;
`ifdef ADC_SAMPLER_AVG_EN
  logic [11:0] hist[$];
  int          acc;
`endif

  always @(posedge ifc.adc_cs or negedge ifc.adc_cs or posedge ifc.adc_clk or negedge reset) begin
    if (reset !== 1'b1) begin
      exp_q.delete();
`ifdef ADC_SAMPLER_AVG_EN
      hist.delete();
`endif
      model_sample = 12'h000;
      rises = 0;
      prev_cs = ifc.adc_cs;
    end else if (ifc.adc_cs !== prev_cs) begin
      prev_cs = ifc.adc_cs;
      if (ifc.adc_cs === 1'b0) begin
        if (word_q.size() > 0) cur_w = word_q.pop_front();
        else if (rand_mode) begin
          cur_w = 16'($urandom);
          if ($urandom_range(0, 2) != 0) cur_w[15:12] = 4'h0;
        end else cur_w = fixed_word;
        rises = 0;
        fall_t.push_back($time);
        e_new.tf  = $time;
        e_new.err = (cur_w[15:12] != 4'h0);
        if (!e_new.err) begin
`ifdef ADC_SAMPLER_AVG_EN
          hist.push_back(cur_w[11:0]);
          if (hist.size() > 4) void'(hist.pop_front());
          acc = 0;
          foreach (hist[i]) acc += int'(hist[i]);
          model_sample = 12'(acc / 4);
`else
          model_sample = cur_w[11:0];
`endif
        end
        e_new.smp = model_sample;
        exp_q.push_back(e_new);
      end else begin
        check("rises_per_frame", rises, 16);
      end
    end else if (ifc.adc_cs === 1'b0 && ifc.adc_clk === 1'b1) begin
      rises++;
    end
  end

  assign ifc.adc_so = (rises < 16) ? cur_w[15 - rises] : 1'b0;

  // Fast instance ADC: always answers 0x0FFF
  int     rises_f = 0;
  logic   prev_cs_f = 1'b1;
  longint fall_tf = 0;
  longint rise_tf[$];

  always @(posedge ifc_f.adc_cs or negedge ifc_f.adc_cs or posedge ifc_f.adc_clk) begin
    if (ifc_f.adc_cs !== prev_cs_f) begin
      prev_cs_f = ifc_f.adc_cs;
      if (ifc_f.adc_cs === 1'b0) begin
        rises_f = 0;
        fall_tf = $time;
        rise_tf.delete();
      end
    end else if (ifc_f.adc_cs === 1'b0 && ifc_f.adc_clk === 1'b1) begin
      rises_f++;
      rise_tf.push_back($time);
    end
  end

  assign ifc_f.adc_so = (rises_f >= 4);

  // ---------------- monitor ----------------
  int          n_valid = 0;
  int          n_err = 0;
  logic [11:0] log_q[$];
  exp_t        e_got;

  always @(negedge clk) begin
    if (reset === 1'b1 && (sample_valid || frame_err)) begin
      check("strobe_exclusive", longint'(sample_valid & frame_err), 0);
      if (sample_valid) begin
        n_valid++;
        log_q.push_back(sample);
      end else begin
        n_err++;
      end
      check("pending_expect", longint'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e_got = exp_q.pop_front();
        check("strobe_is_err", longint'(frame_err), longint'(e_got.err));
        check("sample_value", longint'(sample), longint'(e_got.smp));
        check("latency", ($time - e_got.tf - 10) / TCLK, LAT);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("idle_reached", longint'(busy), 0);
  endtask

  task automatic wait_falls(input int target, input int max_cyc);
    int n;
    n = 0;
    while (fall_t.size() < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("falls_reached", longint'(fall_t.size() >= target), 1);
  endtask

  task automatic wait_valids(input int target, input int max_cyc);
    int n;
    n = 0;
    while (n_valid < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("valids_reached", longint'(n_valid >= target), 1);
  endtask

  initial begin
    int nf, nv, ne, n, base;
    longint t_en;
    logic [11:0] seq_exp [4];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", longint'(ifc.adc_cs), 1);
    check("rst_sclk", longint'(ifc.adc_clk), 1);
    check("rst_sample", longint'(sample), 0);
    check("rst_valid", longint'(sample_valid), 0);
    check("rst_err", longint'(frame_err), 0);
    check("rst_busy", longint'(busy), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("no_en_cs", longint'(ifc.adc_cs), 1);
    check("no_en_busy", longint'(busy), 0);

    // Back-to-back frames of 0x0ABC
    nf = fall_t.size();
    en = 1'b1;
    t_en = $time;
    wait_falls(nf + 3, 400);
    check("first_fall", fall_t[nf] - t_en, 10);
    check("period_1", fall_t[nf + 1] - fall_t[nf], PER * TCLK);
    check("period_2", fall_t[nf + 2] - fall_t[nf + 1], PER * TCLK);
    en = 1'b0;
    wait_idle(200);

    // One-clock enable pulse with a rejected word
    fixed_word = 16'h8123;
    nf = fall_t.size();
    nv = n_valid;
    ne = n_err;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_idle(200);
    repeat (20) @(negedge clk);
    check("pulse_one_frame", fall_t.size() - nf, 1);
    check("err_once", n_err - ne, 1);
    check("no_valid_on_err", n_valid - nv, 0);
    check("rest_cs", longint'(ifc.adc_cs), 1);
    check("rest_busy", longint'(busy), 0);

    // Randomized words with enable toggling mid-frame
    rand_mode = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) en = ~en;
    end
    en = 1'b0;
    wait_idle(300);
    check("queue_drained", exp_q.size(), 0);

    // Reset at the 8th adc_clk rise
    rand_mode = 1'b0;
    fixed_word = 16'h0ABC;
    en = 1'b1;
    n = 0;
    while (ifc.adc_cs !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (rises < 8 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_rise8", rises, 8);
    reset = 1'b0;
    #1;
    check("abort_cs", longint'(ifc.adc_cs), 1);
    check("abort_sclk", longint'(ifc.adc_clk), 1);
    check("abort_valid", longint'(sample_valid), 0);
    check("abort_err", longint'(frame_err), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_sample", longint'(sample), 0);
    repeat (3) @(negedge clk);
    nv = n_valid;
    reset = 1'b1;
    wait_valids(nv + 1, 200);
    en = 1'b0;
    wait_idle(200);
    check("post_reset_frame", n_valid - nv, 1);

    // Four known results from a cleared history
`ifdef ADC_SAMPLER_AVG_EN
    seq_exp = '{12'h040, 12'h0C0, 12'h180, 12'h280};
`else
    seq_exp = '{12'h100, 12'h200, 12'h300, 12'h400};
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    word_q = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    fixed_word = 16'h0400;
    base = log_q.size();
    nv = n_valid;
    en = 1'b1;
    wait_valids(nv + 4, 400);
    en = 1'b0;
    wait_idle(200);
    for (int i = 0; i < 4; i++) check($sformatf("seq_sample_%0d", i), longint'(log_q[base + i]), longint'(seq_exp[i]));

    // Fastest serial clock on the second instance
    en_f = 1'b1;
    @(negedge clk);
    en_f = 1'b0;
    n = 0;
    while (!valid_f && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fast_valid_seen", longint'(valid_f), 1);
    check("fast_err", longint'(err_f), 0);
`ifdef ADC_SAMPLER_AVG_EN
    check("fast_sample", longint'(sample_f), 12'h3FF);
`else
    check("fast_sample", longint'(sample_f), 12'hFFF);
`endif
    check("fast_rises", rises_f, 16);
    check("fast_sclk_period", rise_tf[1] - rise_tf[0], 2 * TCLK);
    check("fast_latency", ($time - fall_tf - 10) / TCLK, 34);
    repeat (5) @(negedge clk);
    check("fast_idle", longint'(busy_f), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
